// File: rtl/rd_cost_selector.sv
`default_nettype none
// ============================================================================
// Module   : rd_cost_selector
// Brief    : Two-stage pipelined RD-cost minimum search over quantiser candidates.
// Revision : 1.0
// ============================================================================
module rd_cost_selector #(
   parameter int LAMBDA_FRAC = 8,
   parameter int LVL_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      lambda,
   input  logic             cand_valid,
   output logic             cand_ready,
   input  logic [LVL_W-1:0] cand_level,
   input  logic [31:0]      cand_dist,
   input  logic [31:0]      cand_rate,
   input  logic             cand_last,
   output logic [LVL_W-1:0] best_level,
   output logic [47:0]      best_cost,
   output logic [31:0]      best_rate,
   output logic [3:0]       cand_count,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   localparam logic [47:0] c_COST_INIT = 48'hFFFF_FFFF_FFFF;
   localparam logic [3:0]  c_CNT_MAX   = 4'd15;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_drain_cnt;
   logic [15:0]      r_lambda;
   logic             w_hs;
   logic             w_start_acc;
   logic [47:0]      w_prod;
   logic [47:0]      w_cost;

   logic             r_s1_vld;
   logic [47:0]      r_s1_prod;
   logic [LVL_W-1:0] r_s1_level;
   logic [31:0]      r_s1_dist;
   logic [31:0]      r_s1_rate;

   assign cand_ready  = (r_state == ST_COLLECT);
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DRAIN) && r_drain_cnt;
   assign w_hs        = cand_valid && cand_ready;
   assign w_start_acc = start && (r_state == ST_IDLE);
   assign w_prod      = {32'd0, r_lambda} * {16'd0, cand_rate};
   // Product >> frac is at most 40 bits, so the 48-bit sum cannot overflow.
   assign w_cost      = {16'd0, r_s1_dist} + (r_s1_prod >> LAMBDA_FRAC);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (start)             w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (w_hs && cand_last) w_state_nxt = ST_DRAIN;
         ST_DRAIN:   if (r_drain_cnt)       w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= 1'b0;
         r_lambda    <= 16'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
         if (w_start_acc)
            r_lambda <= lambda;
      end
   end

   // Stage 1: product and candidate fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld   <= 1'b0;
         r_s1_prod  <= 48'd0;
         r_s1_level <= '0;
         r_s1_dist  <= 32'd0;
         r_s1_rate  <= 32'd0;
      end else begin
         r_s1_vld <= w_hs;
         if (w_hs) begin
            r_s1_prod  <= w_prod;
            r_s1_level <= cand_level;
            r_s1_dist  <= cand_dist;
            r_s1_rate  <= cand_rate;
         end
      end
   end

   // Stage 2: strict-less compare keeps the earliest candidate on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_level <= '0;
         best_cost  <= 48'd0;
         best_rate  <= 32'd0;
      end else if (w_start_acc) begin
         best_level <= '0;
         best_cost  <= c_COST_INIT;
         best_rate  <= 32'd0;
      end else if (r_s1_vld && (w_cost < best_cost)) begin
         best_level <= r_s1_level;
         best_cost  <= w_cost;
         best_rate  <= r_s1_rate;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cand_count <= 4'd0;
      else if (w_start_acc)
         cand_count <= 4'd0;
      else if (w_hs && (cand_count != c_CNT_MAX))
         cand_count <= cand_count + 4'd1;
   end

endmodule
`default_nettype wire
